// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: opcode mnemonics, the set of
// I-format opcodes, the loader state encoding and the machine word width.
package instr_loader_pkg;

   localparam int kInstrW = 9;

   typedef enum logic [2:0] {
      kLSW = 3'd0,
      kADD = 3'd1,
      kSUB = 3'd2,
      kAND = 3'd3,
      kXOR = 3'd4,
      kBNE = 3'd5,
      kLDI = 3'd6,
      kJMP = 3'd7
   } op_mne;

   // One bit per opcode value; a set bit marks an I-format (op + 6-bit imm) op.
   localparam logic [7:0] kIFmtOps = 8'b1100_0010;   // kADD, kLDI, kJMP

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      DRAIN = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } ld_state;

   // True when the opcode carries an immediate instead of two register fields.
   function automatic logic is_ifmt(input op_mne op);
      return kIFmtOps[op];
   endfunction

endpackage

// File: rtl/instr_loader_fifo.sv
// Small synchronous FIFO buffering encoded words between the field input and
// the instruction-memory write port. Push is ignored when full, pop when empty;
// flush empties the queue in one cycle and wins over push/pop.
module sync_fifo
   import instr_loader_pkg::*;
#(
   parameter int WIDTH = kInstrW,
   parameter int DEPTH = 4
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [PW:0]      level_r;
   logic             do_push_s;
   logic             do_pop_s;

   // Qualify requests against the current occupancy.
   always_comb begin
      do_push_s = push && (level_r != LVL_FULL);
      do_pop_s  = pop && (level_r != {(PW+1){1'b0}});
   end

   // Storage write; contents need no reset because head is only used when non-empty.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         level_r  <= {(PW+1){1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         level_r  <= {(PW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   level_r <= level_r + (PW+1)'(1);
            2'b01:   level_r <= level_r - (PW+1)'(1);
            default: level_r <= level_r;
         endcase
      end
   end

   // Status and head view.
   always_comb begin
      head  = mem_r[rd_ptr_r];
      full  = (level_r == LVL_FULL);
      empty = (level_r == {(PW+1){1'b0}});
      level = level_r;
   end

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: encodes symbolic instruction fields into 9-bit machine
// words, buffers them, and writes them to consecutive instruction-memory
// addresses. A write at the top address with more words still to come is an
// overflow: the write completes, the rest of the program is discarded and the
// sticky Error flag is raised instead of wrapping the address.
module instr_loader #(
   parameter int DEPTH = 4,
   parameter int AW    = 8
)(
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic [AW-1:0] StartAddr,
   input  logic          InValid,
   output logic          InReady,
   input  logic [2:0]    InOp,
   input  logic [2:0]    InA,
   input  logic [2:0]    InB,
   input  logic [5:0]    InImm,
   input  logic          InLast,
   output logic          MemWrEn,
   output logic [AW-1:0] MemAddr,
   output logic [8:0]    MemData,
   input  logic          MemReady,
   output logic          Busy,
   output logic          Done,
   output logic [AW-1:0] Count,
   output logic          Error
);

   import instr_loader_pkg::*;

   localparam int              LW       = $clog2(DEPTH) + 1;
   localparam logic [AW-1:0]   ADDR_MAX = {AW{1'b1}};

   ld_state              state_r;
   ld_state              state_nxt_s;
   logic [AW-1:0]        addr_r;
   logic [AW-1:0]        count_r;
   logic                 error_r;

   op_mne                op_s;
   logic [kInstrW-1:0]   enc_word_s;
   logic                 in_ready_s;
   logic                 push_s;
   logic                 wr_en_s;
   logic                 wr_s;
   logic                 ovf_s;
   logic                 flush_s;
   logic [kInstrW-1:0]   head_s;
   logic                 full_s;
   logic                 empty_s;
   logic [LW-1:0]        level_s;

   // Field encoder: I-format ops carry the immediate, all others two register fields.
   always_comb begin
      op_s = op_mne'(InOp);
      if (is_ifmt(op_s)) begin
         enc_word_s = {InOp, InImm};
      end else begin
         enc_word_s = {InOp, InA, InB};
      end
   end

   // Handshakes on both sides plus overflow detection on the write side.
   always_comb begin
      in_ready_s = (state_r == LOAD) && !full_s;
      push_s     = InValid && in_ready_s;
      wr_en_s    = ((state_r == LOAD) || (state_r == DRAIN)) && !empty_s;
      wr_s       = wr_en_s && MemReady;
      // More words remain if input is still open or the FIFO keeps something after this pop.
      ovf_s      = wr_s && (addr_r == ADDR_MAX) &&
                   ((state_r == LOAD) || (level_s > LW'(1)));
      flush_s    = (state_r == ERR);
   end

   sync_fifo #(
      .WIDTH (kInstrW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (Clk),
      .rst   (Reset),
      .flush (flush_s),
      .push  (push_s),
      .pop   (wr_s),
      .din   (enc_word_s),
      .head  (head_s),
      .full  (full_s),
      .empty (empty_s),
      .level (level_s)
   );

   // FSM state register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; DRAIN finishes on the edge that retires the last word.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (Start) begin
               state_nxt_s = LOAD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOAD: begin
            if (ovf_s) begin
               state_nxt_s = ERR;
            end else if (push_s && InLast) begin
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = LOAD;
            end
         end
         DRAIN: begin
            if (ovf_s) begin
               state_nxt_s = ERR;
            end else if (empty_s || (wr_s && (level_s == LW'(1)))) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         DONE:    state_nxt_s = IDLE;
         ERR:     state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Address, word count and sticky error; the address saturates instead of wrapping.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         addr_r  <= {AW{1'b0}};
         count_r <= {AW{1'b0}};
         error_r <= 1'b0;
      end else if ((state_r == IDLE) && Start) begin
         addr_r  <= StartAddr;
         count_r <= {AW{1'b0}};
         error_r <= 1'b0;
      end else begin
         if (wr_s) begin
            count_r <= count_r + AW'(1);
            if (addr_r != ADDR_MAX) begin
               addr_r <= addr_r + AW'(1);
            end
         end
         if (state_nxt_s == ERR) begin
            error_r <= 1'b1;
         end
      end
   end

   // FSM outputs, all derived from registered state.
   always_comb begin
      InReady = in_ready_s;
      MemWrEn = wr_en_s;
      MemAddr = addr_r;
      Busy    = (state_r != IDLE);
      Done    = (state_r == DONE);
      Count   = count_r;
      Error   = error_r;
      if (wr_en_s) begin
         MemData = head_s;
      end else begin
         MemData = {kInstrW{1'b0}};
      end
   end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Encoder-side counterpart of the control decoder: turns symbolic instruction fields into 9-bit machine words and streams them into instruction memory.
- Used by the bench/bootstrap path to load programs before the core runs.
- Inputs are accepted on a valid/ready handshake, encoded, buffered in a small FIFO, then written to sequential instruction-memory addresses under a memory-ready handshake.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- AW, 8, instruction-memory address width

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  one-cycle pulse: begin a load at StartAddr (honoured only in IDLE)
- StartAddr  in  AW  first write address
- InValid  in  1  field tuple valid
- InReady  out  1  loader can accept the tuple this cycle
- InOp  in  3  opcode mnemonic (op_mne from definitions)
- InA  in  3  R-format field A
- InB  in  3  R-format field B
- InImm  in  6  I-format immediate
- InLast  in  1  tuple is final instruction of program
- MemWrEn  out  1  write request
- MemAddr  out  AW  write address
- MemData  out  9  encoded instruction
- MemReady  in  1  memory accepts write this cycle
- Busy  out  1  state ≠ IDLE
- Done  out  1  one-cycle pulse: all words written
- Count  out  AW  words written in current load
- Error  out  1  sticky until next Start: address overflow

Behaviour:
- Reset (async, immediate): state IDLE; FIFO empty; InReady=0, MemWrEn=0, MemAddr=0, MemData=0, Busy=0, Done=0, Count=0, Error=0.
- Encoding (combinational at input):
  - R-format: {InOp, InA, InB}.
  - I-format (ops listed in package constant kIFmtOps, includes kADD): {InOp, InImm}.
  - Bits [8:3] of every word must decode in Ctrl exactly as the op/field pair given.
- States:
  - IDLE --Start--> LOAD: MemAddr←StartAddr, Count←0, Error←0.
  - LOAD: InReady = !full. A push happens when InValid&&InReady. A push with InLast=1 → DRAIN.
  - DRAIN: InReady=0; when FIFO is empty and no write is pending → DONE.
  - DONE: Done=1 for one cycle → IDLE.
  - ERR: InReady=0, MemWrEn=0; FIFO flushed; Error=1; → IDLE next cycle (Error stays set).
- Write side (LOAD/DRAIN):
  - MemWrEn = !empty; MemData = FIFO head; MemAddr is a register.
  - On MemWrEn&&MemReady: pop, Count+1, MemAddr+1.
  - MemData/MemAddr must be held stable while MemWrEn=1 and MemReady=0.
- Latency: tuple accepted at edge N → MemWrEn earliest in cycle after N. No input-to-memory bypass.
- Full FIFO: InReady=0 even if a pop occurs the same cycle (no pass-through when full). Push and pop in the same cycle when not full are both honoured, and occupancy is unchanged.
- Overflow: a write accepted at MemAddr=2^AW−1 while more words remain (FIFO non-empty after pop, or state LOAD) → ERR; that last write still completes. The address must not wrap silently.
- Last word at 2^AW−1 with nothing pending is legal → DONE.
- Start while Busy: ignored. InValid outside LOAD: ignored, InReady=0.
- Reset mid-load: immediate return to reset values; partially written memory is not rolled back.

Decomposition:
- Package definitions:
  - op_mne enum (existing)
  - kIFmtOps membership function is_ifmt(op)
  - loader state enum ld_state {IDLE, LOAD, DRAIN, DONE, ERR}
  - kInstrW=9
- Sub-module sync_fifo (WIDTH=9, DEPTH), with push, pop, full, empty, head. The encoder stays inline.

Test Plan:
- Start, StartAddr=8'h10; tuples (kLSW,A=3,B=0), (kADD,Imm=6'b000001), (kBNE,A=3,B=2), (kXOR,A=3,B=2,Last), MemReady=1 → writes at 10..13 with {kLSW,011,000}, {kADD,000001}, {kBNE,011,010}, {kXOR,011,010}; Done pulses one cycle after the 4th write; Count=4. Feed MemData[8:3] into Ctrl and check it matches the direct-decode outputs.
- MemReady=0 for 10 cycles during a 6-tuple load → InReady drops after DEPTH=4 pushes; MemAddr/MemData held stable; all 6 words land in order after release.
- StartAddr=8'hFE, 3 tuples → writes at FE and FF, then Error=1 and state ERR→IDLE; no write at 00; Done never asserts.
- StartAddr=8'hFF, single tuple with Last → one write at FF, Done=1, Error=0.
- Reset asserted asynchronously mid-DRAIN (FIFO holding 2) → all outputs reset immediately without waiting for a clock; the next Start at 8'h20 loads cleanly with Count starting at 0.
- Start pulsed during LOAD and InValid held in IDLE → no state change, InReady=0 in IDLE.
